// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the sequential subtractor and the BCD adder.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        NEG  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of subtraction with borrow in/out; also flags non-BCD operand digits.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               bin,
    output logic [DIGIT_W-1:0] d,
    output logic               bout,
    output logic               bad
);

    logic signed [DIGIT_W:0] t;

    always_comb begin
        t    = $signed({1'b0, a_d}) - $signed({1'b0, b_d}) - $signed({4'b0000, bin});
        bout = t[DIGIT_W];
        // Adding ten modulo 16 folds a negative digit back into 0..9.
        d    = bout ? (t[DIGIT_W-1:0] + 4'd10) : t[DIGIT_W-1:0];
        bad  = (a_d > BCD_MAX) || (b_d > BCD_MAX);
    end

endmodule

// File: rtl/bcd_seq_sub.sv
// Digit-serial BCD subtractor A - B, LSD first, with start/busy/done handshake.
// Optional macro BCD_SUB_SIGN_MAG_EN: negative results are re-negated into sign/magnitude form.
module bcd_seq_sub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  borrow,
    output logic                  invalid
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               borrow_int;
    logic               invalid_int;

    logic [DIGIT_W-1:0] a_d;
    logic [DIGIT_W-1:0] b_d;
    logic [DIGIT_W-1:0] d;
    logic               bout;
    logic               bad;

    // The single digit datapath serves RUN (a - b) and, when enabled, NEG (0 - diff).
    always_comb begin
        a_d = a_q[idx*DIGIT_W +: DIGIT_W];
        b_d = b_q[idx*DIGIT_W +: DIGIT_W];
`ifdef BCD_SUB_SIGN_MAG_EN
        if (state == NEG) begin
            a_d = '0;
            b_d = diff[idx*DIGIT_W +: DIGIT_W];
        end
`endif
    end

    bcd_digit_sub u_digit (
        .a_d  (a_d),
        .b_d  (b_d),
        .bin  (borrow_int),
        .d    (d),
        .bout (bout),
        .bad  (bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            borrow_int  <= 1'b0;
            invalid_int <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            diff        <= '0;
            borrow      <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q         <= a;
                        b_q         <= b;
                        idx         <= '0;
                        borrow_int  <= 1'b0;
                        invalid_int <= 1'b0;
                        invalid     <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end

                RUN: begin
                    diff[idx*DIGIT_W +: DIGIT_W] <= d;
                    borrow_int <= bout;
                    if (bad) invalid_int <= 1'b1;
                    if (idx == LAST) begin
`ifdef BCD_SUB_SIGN_MAG_EN
                        if (bout) begin
                            idx        <= '0;
                            borrow_int <= 1'b0;
                            state      <= NEG;
                        end else begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end
`else
                        busy  <= 1'b0;
                        state <= DONE;
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

`ifdef BCD_SUB_SIGN_MAG_EN
                // Negating a nonzero ten's complement always borrows out, so borrow_int ends as the sign.
                NEG: begin
                    diff[idx*DIGIT_W +: DIGIT_W] <= d;
                    borrow_int <= bout;
                    if (idx == LAST) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
`endif

                DONE: begin
                    done    <= 1'b1;
                    borrow  <= borrow_int;
                    invalid <= invalid_int;
                    if (invalid_int) diff <= '0;
                    // Back-to-back start: the reported result stays on the outputs for this done cycle.
                    if (start) begin
                        a_q         <= a;
                        b_q         <= b;
                        idx         <= '0;
                        borrow_int  <= 1'b0;
                        invalid_int <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_sub.sv
// Randomized self-checking bench for bcd_seq_sub (DIGITS=2) against a value-level reference model.
module tb_bcd_seq_sub;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         invalid;

    int n_checks;
    int n_fail;

    logic [W-1:0] exp_q[$];
    logic         exp_borrow_q[$];
    logic         exp_invalid_q[$];

    bcd_seq_sub #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .borrow  (borrow),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int n);
        logic [W-1:0] r;
        int m;
        r = '0;
        m = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) if (v[i*4 +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    // Reference: plain integer subtraction; latency/busy derived from the sign of the result.
    task automatic model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                         output int elat, output int ebusy);
        int av, bv, p10;
        logic bad;
        p10 = 1;
        for (int i = 0; i < DIGITS; i++) p10 = p10 * 10;
        av  = bcd_to_int(aa);
        bv  = bcd_to_int(bb);
        bad = has_bad(aa) || has_bad(bb);
        elat = DIGITS + 1;
        if (bad) begin
            exp_q.push_back('0);
            exp_borrow_q.push_back(1'b0);
        end else if (av >= bv) begin
            exp_q.push_back(int_to_bcd(av - bv));
            exp_borrow_q.push_back(1'b0);
        end else begin
`ifdef BCD_SUB_SIGN_MAG_EN
            exp_q.push_back(int_to_bcd(bv - av));
            elat = 2 * DIGITS + 1;
`else
            exp_q.push_back(int_to_bcd(p10 - (bv - av)));
`endif
            exp_borrow_q.push_back(1'b1);
        end
        exp_invalid_q.push_back(bad);
        ebusy = elat - 1;
    endtask

    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb);
        int elat, ebusy, lat, bsy;
        logic got, ebor, einv, bad;
        logic [W-1:0] ed;
        bad = has_bad(aa) || has_bad(bb);
        model(aa, bb, elat, ebusy);
        @(negedge clk);
        a = aa;
        b = bb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        got = 1'b0;
        lat = 0;
        bsy = busy ? 1 : 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                lat = k;
            end else if (busy) begin
                bsy++;
            end
        end
        ed   = exp_q.pop_front();
        ebor = exp_borrow_q.pop_front();
        einv = exp_invalid_q.pop_front();
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("diff", 32'(diff), 32'(ed));
            check("invalid", 32'(invalid), 32'(einv));
            if (!bad) begin
                check("borrow", 32'(borrow), 32'(ebor));
                check("latency", 32'(lat), 32'(elat));
                check("busy_cycles", 32'(bsy), 32'(ebusy));
            end
            @(posedge clk);
            #1;
            check("done_single", 32'(done), 32'd0);
        end
    endtask

    task automatic rand_pos_pair(output logic [W-1:0] x, output logic [W-1:0] y);
        int u, v, t;
        u = $urandom_range(0, 99);
        v = $urandom_range(0, 99);
        if (u < v) begin
            t = u; u = v; v = t;
        end
        x = int_to_bcd(u);
        y = int_to_bcd(v);
    endtask

    task automatic back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        int lat1, lat2, e1, e2;
        logic got1, got2;
        rand_pos_pair(a1, b1);
        rand_pos_pair(a2, b2);
        model(a1, b1, e1, e2);
        model(a2, b2, e1, e2);
        @(negedge clk);
        a = a1;
        b = b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = a2;
        b = b2;
        got1 = 1'b0;
        got2 = 1'b0;
        lat1 = 0;
        lat2 = 0;
        for (int k = 1; k <= 20 && !got2; k++) begin
            @(posedge clk);
            #1;
            if (done && !got1) begin
                got1 = 1'b1;
                lat1 = k;
                start = 1'b0;
                check("b2b_diff1", 32'(diff), 32'(exp_q.pop_front()));
                check("b2b_borrow1", 32'(borrow), 32'(exp_borrow_q.pop_front()));
                void'(exp_invalid_q.pop_front());
            end else if (done && got1) begin
                got2 = 1'b1;
                lat2 = k;
                check("b2b_diff2", 32'(diff), 32'(exp_q.pop_front()));
                check("b2b_borrow2", 32'(borrow), 32'(exp_borrow_q.pop_front()));
                void'(exp_invalid_q.pop_front());
            end
        end
        start = 1'b0;
        check("b2b_first_latency", 32'(lat1), 32'(DIGITS + 1));
        check("b2b_spacing", 32'(lat2 - lat1), 32'(DIGITS + 1));
        if (!got2) begin
            exp_q.delete();
            exp_borrow_q.delete();
            exp_invalid_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic reset_mid_op();
        int pulses;
        @(negedge clk);
        a = 8'h63;
        b = 8'h18;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_invalid", 32'(invalid), 32'd0);
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("rst_no_done", 32'(pulses), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_borrow", 32'(borrow), 32'd0);
        check("reset_invalid", 32'(invalid), 32'd0);
        rst = 1'b0;

        run_op(8'h85, 8'h27);
        run_op(8'h27, 8'h85);
        run_op(8'h00, 8'h00);
        run_op(8'h99, 8'h99);
        run_op(8'h9A, 8'h01);
        run_op(8'h00, 8'h01);
        run_op(8'h99, 8'h00);

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < DIGITS; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    ra[i*4 +: 4] = 4'($urandom_range(0, 15));
                    rb[i*4 +: 4] = 4'($urandom_range(0, 15));
                end else begin
                    ra[i*4 +: 4] = 4'($urandom_range(0, 9));
                    rb[i*4 +: 4] = 4'($urandom_range(0, 9));
                end
            end
            run_op(ra, rb);
        end

        back_to_back();
        back_to_back();
        reset_mid_op();
        run_op(8'h42, 8'h17);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
